// File: rtl/fp16_result_packer.sv
// Iterative normalize / round-to-nearest-even / pack back end for the FP add/sub datapath.
// Define FP_PACK_FLUSH_EN to flush subnormal results to signed zero instead of packing them.
module fp16_result_packer #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sgn,
  input  logic [MANT_W:0]           in_mant,
  input  logic [EXP_W:0]            in_exp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W-1:0]   out_data,
  output logic [2:0]                out_flags
);

  localparam int PW = 1 + EXP_W + MANT_W - 1;
  // Two bits of headroom so exp+1 on a max-range input cannot wrap.
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  typedef struct packed {
    logic              sgn;
    logic [MANT_W:0]   mant;
    logic [XW-1:0]     exp;
    logic              guard;
  } work_t;

  state_t state, state_nxt;
  work_t  wrk;

  logic            accept;
  logic            in_zero;
  logic            norm_rsh;
  logic            norm_lsh;
  logic [MANT_W:0] rnd_sum;
  logic [MANT_W:0] rnd_mant;
  logic [XW-1:0]   rnd_exp;
  logic [PW-1:0]   pack_data;
  logic [2:0]      pack_flags;

  assign accept   = in_valid && (state == IDLE);
  assign in_zero  = (in_mant == '0);
  assign norm_rsh = wrk.mant[MANT_W];
  assign norm_lsh = !wrk.mant[MANT_W] && !wrk.mant[MANT_W-1] && (wrk.exp > EXP_ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = in_zero ? OUT : NORM;
      NORM:    if (!norm_rsh && !norm_lsh) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == OUT);
  end

  // Round half to even; guard is the only bit below the LSB, so sticky is zero.
  always_comb begin
    rnd_sum  = {1'b0, wrk.mant[MANT_W-1:0]} + (MANT_W+1)'(wrk.guard & wrk.mant[0]);
    rnd_mant = rnd_sum[MANT_W] ? (rnd_sum >> 1) : rnd_sum;
    rnd_exp  = wrk.exp + XW'(rnd_sum[MANT_W]);
  end

  always_comb begin
    pack_data  = '0;
    pack_flags = '0;
    if (rnd_exp >= EXP_MAX) begin
      pack_data  = {wrk.sgn, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
      pack_flags = 3'b101;
    end else if (!rnd_mant[MANT_W-1]) begin
`ifdef FP_PACK_FLUSH_EN
      pack_data  = {wrk.sgn, {(PW-1){1'b0}}};
      pack_flags = {2'b01, wrk.guard | (|rnd_mant[MANT_W-2:0])};
`else
      pack_data  = {wrk.sgn, {EXP_W{1'b0}}, rnd_mant[MANT_W-2:0]};
      pack_flags = {2'b01, wrk.guard};
`endif
    end else begin
      pack_data  = {wrk.sgn, rnd_exp[EXP_W-1:0], rnd_mant[MANT_W-2:0]};
      pack_flags = {2'b00, wrk.guard};
    end
  end

  // Working registers: capture in IDLE, one shift per cycle in NORM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrk <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          wrk.sgn   <= in_sgn;
          wrk.mant  <= in_mant;
          // Exponent 0 carries subnormal semantics: same scale as exponent 1.
          wrk.exp   <= (in_exp == '0) ? EXP_ONE : XW'(in_exp);
          wrk.guard <= 1'b0;
        end
        NORM: if (norm_rsh) begin
          wrk.mant  <= wrk.mant >> 1;
          wrk.guard <= wrk.mant[0];
          wrk.exp   <= wrk.exp + EXP_ONE;
        end else if (norm_lsh) begin
          wrk.mant  <= wrk.mant << 1;
          wrk.exp   <= wrk.exp - EXP_ONE;
        end
        default: ;
      endcase
    end
  end

  // Result registers stay put through OUT so backpressure sees a stable word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_flags <= '0;
    end else if (accept && in_zero) begin
      out_data  <= {in_sgn, {(PW-1){1'b0}}};
      out_flags <= '0;
    end else if (state == ROUND) begin
      out_data  <= pack_data;
      out_flags <= pack_flags;
    end
  end

endmodule

// File: tb/tb_fp16_result_packer.sv
// Directed plus randomized checks of fp16_result_packer against an arithmetic reference model.
module tb_fp16_result_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sgn = 1'b0;
  logic [11:0] in_mant = '0;
  logic [5:0]  in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

  fp16_result_packer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sgn(in_sgn), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] xp);
    checks++;
    assert (obs === xp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, xp);
    end
  endtask

  // Reference: value-level normalize by leading-zero distance, RNE on one guard bit, pack.
  // lat = edges after the accept edge until out_valid is seen high.
  function automatic void model(input logic s, input int mi, input int ei,
                                output logic [15:0] d, output logic [2:0] f,
                                output int lat, output bit rsh);
    int m, e, g, msb, sh;
    m = mi; e = (ei == 0) ? 1 : ei; g = 0; rsh = 0; lat = 0;
    if (m == 0) begin d = {s, 15'b0}; f = 3'b000; return; end
    if (m >= 2048) begin
      g = m % 2; m = m / 2; e = e + 1; rsh = 1; lat = 3;
    end else begin
      msb = 0;
      for (int i = 0; i < 12; i++) if (m >= (1 << i)) msb = i;
      sh = 10 - msb;
      if (sh > e - 1) sh = e - 1;
      m = m * (1 << sh); e = e - sh; lat = 2 + sh;
    end
    if (g == 1 && (m % 2) == 1) m = m + 1;
    if (m == 2048) begin m = 1024; e = e + 1; end
    if (e >= 31) begin
      d = {s, 5'h1F, 10'h000}; f = 3'b101;
    end else if (m < 1024) begin
      d = {s, 5'h00, 10'(m)}; f = {2'b01, 1'(g)};
    end else begin
      d = {s, 5'(e), 10'(m)}; f = {2'b00, 1'(g)};
    end
  endfunction

  // One full transaction with out_ready high; xlat < 0 skips the latency check.
  task automatic do_op(input string tag, input logic s, input logic [11:0] m, input logic [5:0] e,
                       input logic [15:0] xd, input logic [2:0] xf, input int xlat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_sgn = s; in_mant = m; in_exp = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    if (xlat >= 0) chk({tag, ".lat"}, 32'(n), 32'(xlat));
    chk({tag, ".data"}, 32'(out_data), 32'(xd));
    chk({tag, ".flags"}, 32'(out_flags), 32'(xf));
    @(posedge clk); #1;
    chk({tag, ".handoff"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] md;
    logic [2:0]  mf;
    int          ml, n;
    bit          rs;
    logic        rs_sgn;
    logic [11:0] rm;
    logic [5:0]  re;

    #23;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_flags", 32'(out_flags), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("one",      1'b0, 12'h400, 6'd15, 16'h3C00, 3'b000, 2);
    do_op("carry",    1'b0, 12'hC00, 6'd15, 16'h4200, 3'b000, -1);
    do_op("tie_even", 1'b0, 12'hC01, 6'd15, 16'h4200, 3'b001, -1);
    do_op("tie_up",   1'b0, 12'hC03, 6'd15, 16'h4202, 3'b001, -1);
    do_op("lshift10", 1'b0, 12'h001, 6'd15, 16'h1400, 3'b000, 12);
    do_op("ovf_pos",  1'b0, 12'h800, 6'd30, 16'h7C00, 3'b101, -1);
    do_op("ovf_neg",  1'b1, 12'h800, 6'd30, 16'hFC00, 3'b101, -1);
    do_op("subnorm",  1'b0, 12'h100, 6'd2,  16'h0200, 3'b010, 3);
    do_op("zero_neg", 1'b1, 12'h000, 6'd9,  16'h8000, 3'b000, 0);
    do_op("exp0",     1'b0, 12'h200, 6'd0,  16'h0200, 3'b010, 2);
    do_op("rnd_ovf",  1'b0, 12'hFFF, 6'd29, 16'h7C00, 3'b101, -1);

    // Backpressure: word held, input blocked, extra in_valid ignored.
    out_ready = 1'b0;
    in_sgn = 1'b0; in_mant = 12'hC03; in_exp = 6'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp.valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_sgn = 1'b1; in_mant = 12'h7FF; in_exp = 6'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_data",  32'(out_data),  32'h4202);
      chk("bp.hold_flags", 32'(out_flags), 32'b001);
      chk("bp.in_ready",   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_ready", 32'(in_ready),  32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("bp.no_extra", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of normalization.
    in_sgn = 1'b1; in_mant = 12'h001; in_exp = 6'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out_data",  32'(out_data),  32'd0);
    chk("arst.out_flags", 32'(out_flags), 32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("arst.no_stale", 32'(n), 32'd0);
    do_op("post_rst", 1'b0, 12'h400, 6'd15, 16'h3C00, 3'b000, 2);

    // Random results, mantissas skewed across all leading-zero counts.
    for (int k = 0; k < 200; k++) begin
      rs_sgn = 1'(($urandom) & 1);
      rm = 12'($urandom_range(0, 4095) >> $urandom_range(0, 12));
      re = 6'($urandom_range(0, 40));
      model(rs_sgn, int'(rm), int'(re), md, mf, ml, rs);
      do_op("rand", rs_sgn, rm, re, md, mf, rs ? -1 : ml);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
